// File: rtl/gf2m_pkg.sv
// gf2m_pkg: shared field parameters, FSM state type and
// fold-count helper for the GF(2^m) multiply/reduce datapath.
package gf2m_pkg;

    localparam int M = 521;
    localparam logic [M-1:0] R_POLY = (M'(1) << 32) | M'(1);

    typedef enum logic [1:0] {
        IDLE,
        FOLD,
        DONE
    } red_state_t;

    // Number of D-wide windows needed to clear bits M..2M-2.
    function automatic int nfold(input int m, input int d);
        return (m - 1 + d - 1) / d;
    endfunction

endpackage

// File: rtl/gf2m_fold_window.sv
// gf2m_fold_window: clears acc[t:b] and folds those coefficients
// back in, multiplied carry-lessly by r(x), at offset b-M.
module gf2m_fold_window #(
    parameter int              M      = gf2m_pkg::M,
    parameter int              D      = 65,
    parameter logic [M-1:0]    R_POLY = gf2m_pkg::R_POLY,
    parameter int              IW     = $clog2(2 * M - 1)
) (
    input  logic [2*M-2:0] acc,
    input  logic [IW-1:0]  t,
    input  logic [IW-1:0]  b,
    output logic [2*M-2:0] acc_next
);

    localparam int AW = 2 * M - 1;
    localparam int PW = D + M;

    logic [AW-1:0] win;
    logic [AW-1:0] hi_full;
    logic [AW-1:0] prod_sh;
    logic [D-1:0]  hi;
    logic [PW-1:0] term [M];
    logic [PW-1:0] prod;

    assign win = ({AW{1'b1}} >> (IW'(AW - 1) - t))
               & ({AW{1'b1}} << b);
    assign hi_full = (acc & win) >> b;
    assign hi = hi_full[D-1:0];

    // One shifted copy of hi per set tap of r(x).
    for (genvar j = 0; j < M; j++) begin : g_tap
        if (R_POLY[j]) begin : g_set
            if (j + D > M) begin : g_bad
                $error("gf2m_fold_window: deg(R_POLY)+D > M");
            end
            assign term[j] = PW'(hi) << j;
        end else begin : g_clr
            assign term[j] = '0;
        end
    end

    always_comb begin
        prod = '0;
        for (int j = 0; j < M; j++) begin
            prod = prod ^ term[j];
        end
    end

    assign prod_sh  = AW'(prod) << (b - IW'(M));
    assign acc_next = (acc & ~win) ^ prod_sh;

endmodule

// File: rtl/gf2m_poly_reducer.sv
// gf2m_poly_reducer: iterative reduction of a 2M-bit carry-less
// product modulo x^M + r(x), D coefficients per cycle.
module gf2m_poly_reducer #(
    parameter int           M      = gf2m_pkg::M,
    parameter int           D      = 65,
    parameter logic [M-1:0] R_POLY = gf2m_pkg::R_POLY
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2*M-1:0] in_prod,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] out_c,
    output logic         busy
);

    import gf2m_pkg::*;

    localparam int AW    = 2 * M - 1;
    localparam int IW    = $clog2(AW);
    localparam int NFOLD = nfold(M, D);
    localparam int KW    = $clog2(NFOLD + 1);

    if (D < 1) begin : g_bad_d
        $error("gf2m_poly_reducer: D must be >= 1");
    end

    red_state_t    state;
    red_state_t    state_nx;
    logic [AW-1:0] acc;
    logic [AW-1:0] acc_nx;
    logic [AW-1:0] acc_fold;
    logic [KW-1:0] k;
    logic [KW-1:0] k_nx;
    logic [M-1:0]  out_c_nx;
    logic [IW-1:0] t;
    logic [IW-1:0] b;

    // Window top walks down by D; the base never drops below M.
    always_comb begin
        t = IW'(AW - 1) - IW'(k) * IW'(D);
        b = (t >= IW'(M + D - 1)) ? t - IW'(D - 1) : IW'(M);
    end

    gf2m_fold_window #(
        .M      (M),
        .D      (D),
        .R_POLY (R_POLY),
        .IW     (IW)
    ) u_fold (
        .acc      (acc),
        .t        (t),
        .b        (b),
        .acc_next (acc_fold)
    );

    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        k_nx     = k;
        out_c_nx = out_c;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    acc_nx   = in_prod[AW-1:0];
                    k_nx     = '0;
                    state_nx = FOLD;
                end
            end
            FOLD: begin
                acc_nx = acc_fold;
                k_nx   = k + KW'(1);
                if (k == KW'(NFOLD - 1)) begin
                    state_nx = DONE;
                    out_c_nx = acc_fold[M-1:0];
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            k     <= '0;
            out_c <= '0;
        end else begin
            state <= state_nx;
            acc   <= acc_nx;
            k     <= k_nx;
            out_c <= out_c_nx;
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_gf2m_poly_reducer.sv
// tb_gf2m_poly_reducer: scoreboard bench; stimulus pushes expected
// results, a negedge monitor pops and compares on each handshake.
module tb_gf2m_poly_reducer;

    localparam int M  = 521;
    localparam int PW = 2 * M;
    localparam logic [M-1:0] RP = (M'(1) << 32) | M'(1);

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_prod;
    logic          out_valid;
    logic          out_ready;
    logic [M-1:0]  out_c;
    logic          busy;

    int n_chk  = 0;
    int n_pass = 0;
    logic [M-1:0] exp_q[$];

    always #5 clk = ~clk;

    gf2m_poly_reducer #(
        .M      (M),
        .D      (65),
        .R_POLY (RP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_c     (out_c),
        .busy      (busy)
    );

    task automatic check(input string name,
                         input logic [M-1:0] got,
                         input logic [M-1:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h want %h", name, got, want);
    endtask

    // Bit-serial reference: cancel the top coefficient one at a time.
    function automatic logic [M-1:0] ref_reduce(input logic [PW-1:0] p);
        logic [PW-1:0] a;
        logic [PW-1:0] rr;
        a = p;
        a[PW-1] = 1'b0;
        rr = '0;
        rr[M-1:0] = RP;
        for (int i = PW - 2; i >= M; i--) begin
            if (a[i]) begin
                a[i] = 1'b0;
                a = a ^ (rr << (i - M));
            end
        end
        return a[M-1:0];
    endfunction

    function automatic logic [PW-1:0] bit_p(input int i);
        logic [PW-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_out: got %h want none", out_c);
            end else begin
                check("result", out_c, exp_q.pop_front());
            end
        end
    end

    task automatic send(input logic [PW-1:0] p,
                        input logic [M-1:0] e,
                        output int waited);
        waited = 0;
        in_valid = 1'b1;
        in_prod = p;
        while (!in_ready && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) begin
            n_chk++;
            $display("FAIL send_timeout: got in_ready=0 want 1");
            in_valid = 1'b0;
        end else begin
            exp_q.push_back(e);
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() > 0) begin
            n_chk++;
            $display("FAIL drain_timeout: got %0d pending want 0",
                     exp_q.size());
            exp_q.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [M-1:0]   e1040;
        logic [M-1:0]   e;
        logic [PW-1:0]  p;
        logic [1055:0]  tmp;
        int             w;
        int             lat;
        logic           ir_low;
        logic           ov_seen;

        rst = 1'b1;
        in_valid = 1'b0;
        in_prod = '0;
        out_ready = 1'b0;
        e1040 = '0;
        e1040[519] = 1'b1;
        e1040[62] = 1'b1;
        e1040[30] = 1'b1;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_in_ready", M'(in_ready), M'(1));
        check("rst_out_valid", M'(out_valid), M'(0));
        check("rst_busy", M'(busy), M'(0));
        check("rst_out_c", out_c, '0);

        // Zero product: latency and in_ready during folding.
        out_ready = 1'b1;
        send('0, '0, w);
        lat = 0;
        ir_low = 1'b1;
        while (!out_valid && lat < 50) begin
            if (in_ready || !busy) ir_low = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        check("latency", M'(lat), M'(8));
        check("in_ready_low", M'(ir_low), M'(1));
        drain();

        send(bit_p(521), RP, w);
        send(bit_p(1040), e1040, w);
        send(PW'(16'h1234), M'(16'h1234), w);
        send(bit_p(1041), '0, w);
        send(bit_p(1041) | bit_p(521), RP, w);
        drain();

        // Backpressure: result held, stalled product not taken.
        out_ready = 1'b0;
        send(bit_p(1040), e1040, w);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = (i == 1 || i == 2);
            in_prod = PW'(16'h1234);
            check("stall_out_c", out_c, e1040);
            check("stall_in_ready", M'(in_ready), M'(0));
            check("stall_out_valid", M'(out_valid), M'(1));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("stall_held", M'(out_valid), M'(1));
        out_ready = 1'b1;
        send(PW'(16'h1234), M'(16'h1234), w);
        check("reaccept_wait", M'(w), M'(1));
        check("reaccept_taken", M'(in_ready), M'(0));
        drain();

        // Reset in the middle of folding discards the operation.
        check("abort_ready", M'(in_ready), M'(1));
        in_valid = 1'b1;
        in_prod = bit_p(1040);
        @(posedge clk); #1;
        in_valid = 1'b0;
        ov_seen = 1'b0;
        repeat (4) begin
            ov_seen = ov_seen | out_valid;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_in_ready", M'(in_ready), M'(1));
        check("abort_busy", M'(busy), M'(0));
        repeat (12) begin
            ov_seen = ov_seen | out_valid;
            @(posedge clk); #1;
        end
        check("abort_no_out", M'(ov_seen), M'(0));
        send(bit_p(521), RP, w);
        drain();

        for (int n = 0; n < 1000; n++) begin
            for (int i = 0; i < 33; i++) tmp[i*32 +: 32] = $urandom;
            p = tmp[PW-1:0];
            e = ref_reduce(p);
            send(p, e, w);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/gf2m_poly_reducer.md
Name: gf2m_poly_reducer

Overview:
- Sequential modular reduction stage that sits directly downstream of the three-way Toom-Cook GF(2) multiplier.
- Consumes the 2M-bit carry-less product and reduces it modulo f(x) = x^M + r(x), returning the M-bit field element.
- Iterative folding: each cycle clears a D-bit window of high-order coefficients and XORs them back in, multiplied by r(x).
- Valid/ready handshakes on both sides decouple it from the fixed-latency multiplier and from downstream consumers.

Parameters:
- M, 521, field degree; input product width is 2*M.
- R_POLY, M-bit mask with bits 32 and 0 set, low part r(x) of f(x) = x^521 + x^32 + 1.
- D, 65, coefficients folded per cycle; legal only if deg(R_POLY) + D <= M and D >= 1.
- NFOLD, ceil((M-1)/D) = 8, derived, number of fold cycles; not overridable.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- in_valid  in  1  product available
- in_ready  out  1  block can accept a product
- in_prod  in  2*M  carry-less product, bit i = coefficient of x^i
- out_valid  out  1  reduced result available
- out_ready  in  1  downstream accepts result
- out_c  out  M  reduced element, degree < M
- busy  out  1  state != IDLE

Behaviour:
- Reset rst is synchronous and active-high; the clock is clk.
- Reset values: state IDLE, in_ready 1, out_valid 0, out_c 0, busy 0, accumulator 0, fold counter 0.
- Storage: 2M-1-bit accumulator acc (bits 0..2M-2) and a fold counter k of ceil(log2(NFOLD+1)) bits.
- in_prod[2M-1] is masked to 0 on load. A valid GF(2) product has degree <= 2M-2, so this bit is always 0 from the multiplier.
- FSM IDLE, in_ready=1:
  - on in_valid: load acc from in_prod, set k=0, go to FOLD.
- FSM FOLD, in_ready=0:
  - window top t = 2M-2 - k*D; base b = max(M, t-D+1).
  - hi = acc[t:b].
  - acc_next = (acc with [t:b] cleared) XOR ((hi * r(x)) << (b-M)), where * is carry-less multiplication.
  - Folded bits land strictly below b because deg(r) + D <= M; no re-fold within the same window is needed.
  - k increments each cycle. After the fold with k = NFOLD-1, go to DONE and register out_c = acc_next[M-1:0].
- FSM DONE, out_valid=1:
  - out_c is held stable.
  - on out_ready: go to IDLE, drop out_valid. in_ready rises on the following cycle; there is no same-cycle re-accept.
- Latency: out_valid is first high NFOLD (8) clock edges after the accepting edge.
- Throughput: one result per NFOLD+2 cycles minimum.
- in_valid while not IDLE is ignored; the upstream side must hold the product until in_ready.
- out_ready while not DONE is ignored.
- Reset mid-FOLD or mid-DONE: the operation is discarded, no output is produced, and the block is in IDLE with in_ready=1 on the cycle after reset deasserts.
- Carry-less hi * r is implemented as the XOR of hi shifted by each set bit position of R_POLY (generate loop over R_POLY bits). No integer adders are permitted.
- Elaboration fails if deg(R_POLY) + D > M or D < 1.

Decomposition:
- Shared package gf2m_pkg holds:
  - M and the default R_POLY;
  - the state enum {IDLE, FOLD, DONE};
  - the NFOLD computation function.
- The multiplier wrapper uses the same package.
- One combinational sub-module, gf2m_fold_window (parameters M, D, R_POLY): takes acc, t and b, returns acc_next.
- The FSM, counter and handshake logic stay in gf2m_poly_reducer.

Test Plan:
- in_prod = 0 -> out_c = 0; out_valid first high exactly 8 edges after acceptance; in_ready low throughout.
- in_prod = x^521 (bit 521 only) -> out_c = bit32 | bit0.
- in_prod = x^1040 (bit 1040 only) -> out_c = bits {519, 62, 30}; in_prod = 0x1234 (degree < M) -> out_c = 0x1234 unchanged.
- in_prod with only bit 1041 set -> out_c = 0 (masked). Random 1041-bit products, 1000 vectors -> match the bit-serial reference model of the modulo f(x) reduction.
- out_ready held low 5 cycles after out_valid, with in_valid pulsed during the stall -> out_c stable, in_ready 0, the stalled product not accepted; it is accepted on the first cycle in_ready returns to 1.
- rst asserted for 1 cycle at fold k=4 -> out_valid never rises for that operation; in_ready=1 on the next cycle; the next product x^521 reduces correctly to bit32 | bit0.
